// File: rtl/event_collector_if.sv
// Event collector handshake bundle: event inputs, wait/ack
// handshake and the delivered-event and status outputs.
interface event_collector_if #(
  parameter int N_EVENTS = 3
);
  localparam int ID_W = $clog2(N_EVENTS);

  logic [N_EVENTS-1:0] ev_i;
  logic                wait_req;
  logic                ack;
  logic                out_valid;
  logic [ID_W-1:0]     out_id;
  logic [N_EVENTS-1:0] out_mask;
  logic                armed;
  logic                timeout;
  logic [N_EVENTS-1:0] pending;
  logic [7:0]          ovr_cnt;

  modport master (
    output ev_i, wait_req, ack,
    input  out_valid, out_id, out_mask,
    input  armed, timeout, pending, ovr_cnt
  );

  modport slave (
    input  ev_i, wait_req, ack,
    output out_valid, out_id, out_mask,
    output armed, timeout, pending, ovr_cnt
  );
endinterface

// File: rtl/event_collector.sv
// Sticky per-source event collector delivering one
// round-robin-selected event per consumer wait request.
module event_collector #(
  parameter int N_EVENTS = 3,
  parameter int TIMEOUT  = 0
) (
  input logic               clk,
  input logic               rst_n,
  event_collector_if.slave  bus
);
  localparam int ID_W  = $clog2(N_EVENTS);
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] TO_LAST =
    CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [ID_W-1:0] ID_LAST = ID_W'(N_EVENTS - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ARMED,
    S_DELIVER
  } state_e;

  state_e              state_q, state_d;
  logic [N_EVENTS-1:0] pending_q, pending_d;
  logic [7:0]          ovr_cnt_q, ovr_cnt_d;
  logic [ID_W-1:0]     rr_q, rr_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                out_valid_q, out_valid_d;
  logic [ID_W-1:0]     out_id_q, out_id_d;
  logic [N_EVENTS-1:0] out_mask_q, out_mask_d;
  logic                armed_q, armed_d;
  logic                timeout_q, timeout_d;

  logic                gnt_vld;
  logic [ID_W-1:0]     gnt_id;
  logic [ID_W-1:0]     idx;
  logic [N_EVENTS-1:0] clr;
  logic [N_EVENTS-1:0] ovr;
  logic [4:0]          ovr_n;
  logic [8:0]          ovr_sum;

  // Round-robin search: first pending source at or above rr_q, wrapping.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_id  = '0;
    idx     = '0;
    for (int k = 0; k < N_EVENTS; k++) begin
      if (int'(rr_q) + k >= N_EVENTS) begin
        idx = ID_W'(int'(rr_q) + k - N_EVENTS);
      end else begin
        idx = ID_W'(int'(rr_q) + k);
      end
      if (!gnt_vld && pending_q[idx]) begin
        gnt_vld = 1'b1;
        gnt_id  = idx;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rr_d       = rr_q;
    out_id_d   = out_id_q;
    out_mask_d = out_mask_q;
    timeout_d  = 1'b0;
    clr        = '0;
    unique case (state_q)
      S_IDLE: begin
        if (bus.wait_req) begin
          state_d = S_ARMED;
          cnt_d   = '0;
        end
      end
      S_ARMED: begin
        if (gnt_vld) begin
          out_id_d   = gnt_id;
          out_mask_d = N_EVENTS'(1) << gnt_id;
          clr        = N_EVENTS'(1) << gnt_id;
          rr_d       = (gnt_id == ID_LAST) ? '0 : gnt_id + 1'b1;
          state_d    = S_DELIVER;
        end else if (TIMEOUT > 0) begin
          if (cnt_q == TO_LAST) begin
            timeout_d = 1'b1;
            state_d   = S_IDLE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      S_DELIVER: begin
        if (bus.ack) begin
          state_d    = S_IDLE;
          out_mask_d = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // A grant-clear coinciding with a new pulse keeps the bit set.
    pending_d = (pending_q & ~clr) | bus.ev_i;
    ovr       = bus.ev_i & pending_q & ~clr;
    ovr_n     = '0;
    for (int i = 0; i < N_EVENTS; i++) begin
      ovr_n = ovr_n + 5'(ovr[i]);
    end
    ovr_sum   = {1'b0, ovr_cnt_q} + {4'b0, ovr_n};
    ovr_cnt_d = (ovr_sum > 9'd255) ? 8'hFF : ovr_sum[7:0];

    out_valid_d = (state_d == S_DELIVER);
    armed_d     = (state_d == S_ARMED);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      pending_q   <= '0;
      ovr_cnt_q   <= '0;
      rr_q        <= '0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      out_id_q    <= '0;
      out_mask_q  <= '0;
      armed_q     <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      pending_q   <= pending_d;
      ovr_cnt_q   <= ovr_cnt_d;
      rr_q        <= rr_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      out_id_q    <= out_id_d;
      out_mask_q  <= out_mask_d;
      armed_q     <= armed_d;
      timeout_q   <= timeout_d;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_id    = out_id_q;
  assign bus.out_mask  = out_mask_q;
  assign bus.armed     = armed_q;
  assign bus.timeout   = timeout_q;
  assign bus.pending   = pending_q;
  assign bus.ovr_cnt   = ovr_cnt_q;
endmodule

// File: doc/event_collector.md
# event_collector

Collects single-cycle event pulses from N independent sources and hands exactly one of them, tagged with its source ID, to a consumer that has signalled it is waiting. It sits directly upstream of a wait-for-any-event consumer. The consumer posts a wait request, the collector returns the next pending event and holds it until acknowledged. Events that arrive while nobody is waiting are remembered per source, not lost.

## Interface
- N_EVENTS, 3: number of event sources, 2..16.
- TIMEOUT, 0: cycles in ARMED before giving up; 0 disables the timeout.
- ID_W, $clog2(N_EVENTS): width of out_id (derived, not overridden).

- clk  in  1  rising-edge clock; the only clock.
- rst_n  in  1  reset, synchronous and active-low.
- ev_i  in  N_EVENTS  event pulses, one bit per source, sampled each edge.
- wait_req  in  1  single-cycle pulse: consumer is waiting for any event.
- ack  in  1  consumer accepts the delivered event.
- out_valid  out  1  delivered event is present.
- out_id  out  ID_W  source index of the delivered event.
- out_mask  out  N_EVENTS  one-hot of out_id.
- armed  out  1  high while in ARMED.
- timeout  out  1  one-cycle pulse on ARMED expiry.
- pending  out  N_EVENTS  sticky per-source pending bits.
- ovr_cnt  out  8  saturating count of pulses lost to an already-set pending bit.

## Operation
- Pending register: ev_i[i] sampled high sets pending[i], in any state.
- If pending[i] is already set and not being cleared that edge, the pulse is an overrun: ovr_cnt increments, saturating at 255.
- If pending[i] is cleared by a grant and ev_i[i] is high on the same edge, the set wins and pending[i] stays 1. This is not an overrun.
- FSM states: IDLE, ARMED, DELIVER.
- IDLE: wait_req=1 moves to ARMED and clears the timeout counter.
- ARMED, pending nonzero: grant one source by round-robin, starting at rr_ptr and searching upward with wrap.
  - Latch out_id and out_mask, clear the granted pending bit, move to DELIVER.
  - Set rr_ptr = (id+1) mod N_EVENTS.
- ARMED, pending zero, TIMEOUT>0: increment the counter. When the counter reaches TIMEOUT-1, pulse timeout for one cycle and return to IDLE.
- DELIVER: out_valid=1 and out_id/out_mask stay stable. ack=1 returns to IDLE and clears out_valid and out_mask. out_id keeps its last value.
- wait_req is ignored in ARMED and DELIVER (no queueing of requests). ack is ignored outside DELIVER.
- Reset, at any state or mid-delivery: the state goes to IDLE and the reset values below apply on the next edge.

## Timing
- Reset values:
  - out_valid=0, out_id=0, out_mask=0, armed=0, timeout=0.
  - pending=0, ovr_cnt=0, rr_ptr=0, timeout counter=0.
- All outputs are registered.
- Event already pending: wait_req sampled at edge k gives armed=1 after edge k, and out_valid=1 after edge k+1.
- Event arriving while ARMED: ev_i sampled at edge k sets pending after edge k, and out_valid=1 after edge k+1. Latency is 2 edges from the pulse to out_valid.
- ack sampled at edge k gives out_valid=0 after edge k. A new wait_req can be sampled at edge k+1.
- Timeout: armed entered after edge k with nothing pending gives timeout=1 after edge k+TIMEOUT, with armed=0 in that same cycle.
- Simultaneous wait_req and ev_i in IDLE are both taken. The event is visible in ARMED the next cycle.

## Test plan
- **Basic delivery:** reset, then ev_i=3'b010 for 1 cycle, then wait_req.
  - out_valid rises 2 edges after the wait_req edge, with out_id=1 and out_mask=3'b010.
  - After ack: pending=0 and out_valid=0.
- **Waiting first:** wait_req, idle 100 cycles (TIMEOUT=0), then ev_i=3'b100.
  - out_valid=1 with out_id=2 exactly 2 edges after the pulse.
  - armed stays high throughout the wait.
- **Round-robin:** set all three pending, then do three wait_req/ack rounds.
  - Delivered IDs are 0, 1, 2 in that order.
  - Pulse ev_i[0] again, then wait_req: out_id=0.
- **Overrun:** pulse ev_i[0] three times while in IDLE.
  - ovr_cnt=2 and pending=3'b001.
  - Grant src0 while ev_i[0]=1 on the same edge: pending[0] stays 1 and ovr_cnt stays 2.
- **Timeout:** TIMEOUT=10, wait_req with nothing pending.
  - timeout pulses 10 edges later for 1 cycle; state is IDLE and out_valid=0.
  - A later event is held as pending and is not delivered.
- **Reset mid-delivery:** enter DELIVER with out_id=1, then assert rst_n=0 for 1 edge.
  - All outputs return to reset values.
  - ack applied after reset has no effect.
